// File: rtl/ahb_lite_decmux.sv
// rtl/ahb_lite_decmux.sv - AHB-Lite single-master address decoder and response multiplexer
// Lowest-index region wins; unmapped or denied transfers get a built-in two-cycle ERROR.
module ahb_lite_decmux #(
  parameter int                    NUM_SLV  = 4,
  parameter logic [32*NUM_SLV-1:0] SLV_BASE = {32'h60000000, 32'h40000000, 32'h20000000, 32'h00000000},
  parameter logic [32*NUM_SLV-1:0] SLV_MASK = {32'hFFFE0000, 32'hF0000000, 32'hFFF80000, 32'hFFF80000},
  parameter int                    TIMEOUT  = 256
) (
  input  logic                    pll_core_cpuclk,
  input  logic                    pad_cpu_rst_b,
  input  logic [31:0]             biu_pad_haddr,
  input  logic [1:0]              biu_pad_htrans,
  input  logic                    biu_pad_hwrite,
  input  logic [2:0]              biu_pad_hsize,
  input  logic [2:0]              biu_pad_hburst,
  input  logic [3:0]              biu_pad_hprot,
  input  logic [31:0]             biu_pad_hwdata,
  input  logic                    smpu_deny,
  output logic [31:0]             pad_biu_hrdata,
  output logic                    pad_biu_hready,
  output logic [1:0]              pad_biu_hresp,
  output logic [NUM_SLV-1:0]      hsel_s,
  output logic                    hready_in_s,
  output logic [31:0]             haddr_s,
  output logic [1:0]              htrans_s,
  output logic                    hwrite_s,
  output logic [2:0]              hsize_s,
  output logic [2:0]              hburst_s,
  output logic [3:0]              hprot_s,
  output logic [31:0]             hwdata_s,
  output logic                    hmastlock,
  input  logic [32*NUM_SLV-1:0]   hrdata_s,
  input  logic [NUM_SLV-1:0]      hready_s,
  input  logic [2*NUM_SLV-1:0]    hresp_s,
  input  logic                    err_clr,
  output logic                    err_valid,
  output logic [1:0]              err_cause,
  output logic [31:0]             err_addr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_e;

  localparam int DEF = NUM_SLV;
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic               xfer_valid;
  logic               xfer_err;
  logic               accept;
  logic               stall;
  logic               wdog_fire;
  logic               dflt_err_ev;
  logic [NUM_SLV-1:0] hit;
  logic [NUM_SLV-1:0] hit_lo;
  logic [NUM_SLV:0]   dp_sel_q, dp_sel_d;
  logic [31:0]        dp_addr_q, dp_addr_d;
  state_e             state_q, state_d;
  logic [CW-1:0]      stall_cnt_q, stall_cnt_d;
  logic               err_valid_q, err_valid_d;
  logic [1:0]         err_cause_q, err_cause_d;
  logic [31:0]        err_addr_q, err_addr_d;

  assign xfer_valid = biu_pad_htrans[1];

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      hit[i] = ((biu_pad_haddr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]);
    end
  end

  // Isolate the lowest set bit so overlapping regions resolve to the lowest index.
  assign hit_lo      = hit & (~hit + NUM_SLV'(1));
  assign hsel_s      = (xfer_valid && !smpu_deny) ? hit_lo : '0;
  assign xfer_err    = xfer_valid && (smpu_deny || !(|hit));
  assign accept      = pad_biu_hready;
  assign dflt_err_ev = accept && xfer_err;

  assign dp_sel_d  = accept ? {~(|hsel_s), hsel_s} : dp_sel_q;
  assign dp_addr_d = accept ? biu_pad_haddr : dp_addr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      default: if (accept) state_d = xfer_err ? ST_ERR1 : ST_IDLE;
    endcase
  end

  always_comb begin
    pad_biu_hrdata = '0;
    pad_biu_hready = 1'b1;
    pad_biu_hresp  = 2'b00;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (dp_sel_q[i]) begin
        pad_biu_hrdata = hrdata_s[32*i +: 32];
        pad_biu_hready = hready_s[i];
        pad_biu_hresp  = hresp_s[2*i +: 2];
      end
    end
    if (dp_sel_q[DEF]) begin
      pad_biu_hrdata = '0;
      pad_biu_hready = (state_q != ST_ERR1);
      pad_biu_hresp  = (state_q == ST_IDLE) ? 2'b00 : 2'b01;
    end
  end

  assign stall = !dp_sel_q[DEF] && !pad_biu_hready;

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
      localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
      // Counting one past LAST makes the watchdog fire once per stall.
      always_comb begin
        stall_cnt_d = '0;
        if (stall) stall_cnt_d = (stall_cnt_q == SAT) ? SAT : stall_cnt_q + CW'(1);
      end
      assign wdog_fire = stall && (stall_cnt_q == LAST);
    end else begin : g_no_wdog
      assign stall_cnt_d = '0;
      assign wdog_fire   = 1'b0;
    end
  endgenerate

  always_comb begin
    err_valid_d = err_valid_q;
    err_cause_d = err_cause_q;
    err_addr_d  = err_addr_q;
    if (err_clr) begin
      err_valid_d = 1'b0;
      err_cause_d = 2'b00;
      err_addr_d  = '0;
    end else if (!err_valid_q && dflt_err_ev) begin
      err_valid_d = 1'b1;
      err_cause_d = smpu_deny ? 2'b10 : 2'b01;
      err_addr_d  = biu_pad_haddr;
    end else if (!err_valid_q && wdog_fire) begin
      err_valid_d = 1'b1;
      err_cause_d = 2'b11;
      err_addr_d  = dp_addr_q;
    end
  end

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      dp_sel_q    <= {1'b1, {NUM_SLV{1'b0}}};
      dp_addr_q   <= '0;
      state_q     <= ST_IDLE;
      stall_cnt_q <= '0;
      err_valid_q <= 1'b0;
      err_cause_q <= 2'b00;
      err_addr_q  <= '0;
    end else begin
      dp_sel_q    <= dp_sel_d;
      dp_addr_q   <= dp_addr_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      err_valid_q <= err_valid_d;
      err_cause_q <= err_cause_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign hready_in_s = pad_biu_hready;
  assign haddr_s     = biu_pad_haddr;
  assign htrans_s    = biu_pad_htrans;
  assign hwrite_s    = biu_pad_hwrite;
  assign hsize_s     = biu_pad_hsize;
  assign hburst_s    = biu_pad_hburst;
  assign hprot_s     = biu_pad_hprot;
  assign hwdata_s    = biu_pad_hwdata;
  assign hmastlock   = 1'b0;
  assign err_valid   = err_valid_q;
  assign err_cause   = err_cause_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_ahb_lite_decmux.sv
// tb/tb_ahb_lite_decmux.sv - directed and randomized bench for ahb_lite_decmux
// A cycle-level reference model predicts every output from the address map and bus rules.
module tb_ahb_lite_decmux;

  localparam int NS = 4;
  localparam int TO = 8;
  localparam logic [31:0] M_BASE [NS] = '{32'h00000000, 32'h20000000, 32'h40000000, 32'h60000000};
  localparam logic [31:0] M_MASK [NS] = '{32'hFFF80000, 32'hFFF80000, 32'hF0000000, 32'hFFFE0000};

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]   haddr = '0;
  logic [1:0]    htrans = '0;
  logic          hwrite = 1'b0;
  logic [2:0]    hsize = 3'd2;
  logic [2:0]    hburst = '0;
  logic [3:0]    hprot = 4'h3;
  logic [31:0]   hwdata = '0;
  logic          deny = 1'b0;
  logic [32*NS-1:0] hrdata_s = '0;
  logic [NS-1:0] hready_s = '1;
  logic [2*NS-1:0] hresp_s = '0;
  logic          err_clr = 1'b0;

  logic [31:0]   hrdata_o;
  logic          hready_o;
  logic [1:0]    hresp_o;
  logic [NS-1:0] hsel_s;
  logic          hready_in_s;
  logic [31:0]   haddr_s;
  logic [1:0]    htrans_s;
  logic          hwrite_s;
  logic [2:0]    hsize_s;
  logic [2:0]    hburst_s;
  logic [3:0]    hprot_s;
  logic [31:0]   hwdata_s;
  logic          hmastlock;
  logic          err_valid;
  logic [1:0]    err_cause;
  logic [31:0]   err_addr;

  ahb_lite_decmux #(.NUM_SLV(NS), .TIMEOUT(TO)) dut (
    .pll_core_cpuclk(clk),       .pad_cpu_rst_b(rst_b),
    .biu_pad_haddr(haddr),       .biu_pad_htrans(htrans),   .biu_pad_hwrite(hwrite),
    .biu_pad_hsize(hsize),       .biu_pad_hburst(hburst),   .biu_pad_hprot(hprot),
    .biu_pad_hwdata(hwdata),     .smpu_deny(deny),
    .pad_biu_hrdata(hrdata_o),   .pad_biu_hready(hready_o), .pad_biu_hresp(hresp_o),
    .hsel_s(hsel_s),             .hready_in_s(hready_in_s),
    .haddr_s(haddr_s),           .htrans_s(htrans_s),       .hwrite_s(hwrite_s),
    .hsize_s(hsize_s),           .hburst_s(hburst_s),       .hprot_s(hprot_s),
    .hwdata_s(hwdata_s),         .hmastlock(hmastlock),
    .hrdata_s(hrdata_s),         .hready_s(hready_s),       .hresp_s(hresp_s),
    .err_clr(err_clr),           .err_valid(err_valid),     .err_cause(err_cause),
    .err_addr(err_addr)
  );

  int tests = 0;
  int fails = 0;

  // Model: data-phase owner (NS = default slave), remaining default-slave error cycles,
  // consecutive stall count, and the error-capture register.
  int          m_owner = NS;
  int          m_err_left = 0;
  int          m_stall = 0;
  logic [31:0] m_dp_addr = '0;
  logic        m_valid = 1'b0;
  logic [1:0]  m_cause = 2'b00;
  logic [31:0] m_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, required %h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) if ((a & M_MASK[i]) == M_BASE[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return {13'h0000, r[18:0]};
      1: return {13'h0400, r[18:0]};
      2: return {4'h4, r[27:0]};
      3: return {15'h3000, r[16:0]};
      4: return {4'h3, r[27:0]};
      default: return r;
    endcase
  endfunction

  function automatic logic model_ready();
    if (m_owner < NS) return hready_s[m_owner];
    return (m_err_left != 2);
  endfunction

  task automatic model_reset();
    m_owner = NS; m_err_left = 0; m_stall = 0; m_dp_addr = '0;
    m_valid = 1'b0; m_cause = 2'b00; m_addr = '0;
  endtask

  task automatic check_outputs();
    int idx;
    logic [NS-1:0] e_hsel;
    logic [31:0] e_rd;
    logic [1:0] e_resp;
    idx = decode(haddr);
    e_hsel = '0;
    if (htrans[1] && !deny && idx >= 0) e_hsel[idx] = 1'b1;
    if (m_owner < NS) begin
      e_rd = hrdata_s[32*m_owner +: 32];
      e_resp = hresp_s[2*m_owner +: 2];
    end else begin
      e_rd = '0;
      e_resp = (m_err_left > 0) ? 2'b01 : 2'b00;
    end
    check("hsel", 32'(hsel_s), 32'(e_hsel));
    check("hready", 32'(hready_o), 32'(model_ready()));
    check("hready_in_s", 32'(hready_in_s), 32'(model_ready()));
    check("hresp", 32'(hresp_o), 32'(e_resp));
    check("hrdata", hrdata_o, e_rd);
    check("err_valid", 32'(err_valid), 32'(m_valid));
    check("err_cause", 32'(err_cause), 32'(m_cause));
    check("err_addr", err_addr, m_addr);
    check("haddr_s", haddr_s, haddr);
    check("hwdata_s", hwdata_s, hwdata);
    check("hmastlock", 32'(hmastlock), 32'd0);
  endtask

  // Check the current cycle, advance the model across the coming edge, then move past it.
  task automatic step();
    logic rdy, ev;
    logic [1:0] cs;
    logic [31:0] ea;
    int idx;
    #1;
    check_outputs();
    rdy = model_ready();
    ev = 1'b0; cs = 2'b00; ea = '0;
    if (m_owner < NS && !rdy) begin
      m_stall++;
      if (m_stall == TO) begin ev = 1'b1; cs = 2'b11; ea = m_dp_addr; end
    end else begin
      m_stall = 0;
    end
    if (rdy) begin
      idx = decode(haddr);
      m_dp_addr = haddr;
      if (htrans[1] && (deny || idx < 0)) begin
        m_owner = NS; m_err_left = 2;
        ev = 1'b1; cs = deny ? 2'b10 : 2'b01; ea = haddr;
      end else if (htrans[1]) begin
        m_owner = idx; m_err_left = 0;
      end else begin
        m_owner = NS; m_err_left = 0;
      end
    end else if (m_owner == NS) begin
      m_err_left = 1;
    end
    if (err_clr) begin
      m_valid = 1'b0; m_cause = 2'b00; m_addr = '0;
    end else if (!m_valid && ev) begin
      m_valid = 1'b1; m_cause = cs; m_addr = ea;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic d);
    htrans = tr; haddr = a; deny = d;
  endtask

  initial begin
    #2;
    check("rst_hready", 32'(hready_o), 32'd1);
    check("rst_hresp", 32'(hresp_o), 32'd0);
    check("rst_hrdata", hrdata_o, 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b1;

    // Read slave 3 with two wait states.
    drive(2'b10, 32'h6000_0010, 1'b0);
    #1 check("s1_hsel", 32'(hsel_s), 32'h8);
    step();
    drive(2'b00, 32'h0, 1'b0);
    hready_s[3] = 1'b0; hrdata_s[127:96] = 32'hDEAD_BEEF;
    #1 check("s1_wait1", 32'(hready_o), 32'd0);
    step();
    step();
    hready_s[3] = 1'b1;
    #1 check("s1_done", 32'(hready_o), 32'd1);
    check("s1_rdata", hrdata_o, 32'hDEAD_BEEF);
    check("s1_resp", 32'(hresp_o), 32'd0);
    step();

    // Unmapped access.
    drive(2'b10, 32'h3000_0000, 1'b0);
    #1 check("s2_hsel", 32'(hsel_s), 32'd0);
    step();
    drive(2'b00, 32'h0, 1'b0);
    #1 check("s2_err1", {30'd0, hresp_o}, 32'd1);
    check("s2_err1_rdy", 32'(hready_o), 32'd0);
    check("s2_cause", 32'(err_cause), 32'd1);
    check("s2_addr", err_addr, 32'h3000_0000);
    step();
    #1 check("s2_err2_rdy", 32'(hready_o), 32'd1);
    check("s2_err2_resp", 32'(hresp_o), 32'd1);
    step();
    step();

    // SMPU deny, then a back-to-back error before clearing.
    err_clr = 1'b1; step(); err_clr = 1'b0;
    drive(2'b10, 32'h4000_0004, 1'b1);
    #1 check("s3_hsel", 32'(hsel_s), 32'd0);
    step();
    drive(2'b00, 32'h0, 1'b0);
    #1 check("s3_cause", 32'(err_cause), 32'd2);
    step();
    drive(2'b10, 32'h3000_0004, 1'b0);
    step();
    drive(2'b00, 32'h0, 1'b0);
    #1 check("s3_b2b_rdy", 32'(hready_o), 32'd0);
    check("s3_addr_kept", err_addr, 32'h4000_0004);
    step();
    step();

    // Watchdog: slave 0 stalls for 20 cycles.
    err_clr = 1'b1; step(); err_clr = 1'b0;
    drive(2'b10, 32'h0000_0100, 1'b0);
    step();
    drive(2'b00, 32'h0, 1'b0);
    hready_s[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 7) check("s4_pre_fire", 32'(err_valid), 32'd0);
      if (k == 8) begin
        check("s4_fire", 32'(err_valid), 32'd1);
        check("s4_cause", 32'(err_cause), 32'd3);
        check("s4_addr", err_addr, 32'h0000_0100);
      end
    end
    hready_s[0] = 1'b1;
    #1 check("s4_done", 32'(hready_o), 32'd1);
    step();

    // Pipelined owner switching: slave 1, slave 2, unmapped, IDLE.
    err_clr = 1'b1; step(); err_clr = 1'b0;
    hrdata_s = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    drive(2'b10, 32'h2000_0040, 1'b0); step();
    drive(2'b10, 32'h4000_0080, 1'b0);
    #1 check("s5_d1", hrdata_o, 32'h1111_1111);
    step();
    drive(2'b10, 32'h3100_0000, 1'b0);
    #1 check("s5_d2", hrdata_o, 32'h2222_2222);
    step();
    drive(2'b00, 32'h0, 1'b0); step(); step();
    #1 check("s5_idle_rdy", 32'(hready_o), 32'd1);
    check("s5_idle_resp", 32'(hresp_o), 32'd0);
    step();

    // Reset during ERR1.
    drive(2'b10, 32'h3000_0008, 1'b0); step();
    drive(2'b00, 32'h0, 1'b0);
    #1 check("s6_in_err1", 32'(hready_o), 32'd0);
    #1 rst_b = 1'b0;
    #1 check("s6_rst_rdy", 32'(hready_in_s), 32'd1);
    check("s6_rst_resp", 32'(hresp_o), 32'd0);
    check("s6_rst_err", 32'(err_valid), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_b = 1'b1;

    // err_clr together with a new error.
    drive(2'b10, 32'h3000_000C, 1'b0); step();
    drive(2'b00, 32'h0, 1'b0); step();
    drive(2'b10, 32'h3000_0010, 1'b0); err_clr = 1'b1; step();
    err_clr = 1'b0; drive(2'b00, 32'h0, 1'b0);
    #1 check("s6_clr_wins", 32'(err_valid), 32'd0);
    step(); step();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      htrans = 2'($urandom_range(0, 3));
      haddr = rand_addr();
      deny = ($urandom_range(0, 7) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      hwrite = 1'($urandom_range(0, 1));
      hwdata = $urandom;
      for (int s = 0; s < NS; s++) begin
        hready_s[s] = ($urandom_range(0, 3) != 0);
        hrdata_s[32*s +: 32] = $urandom;
        hresp_s[2*s +: 2] = ($urandom_range(0, 9) == 0) ? 2'b01 : 2'b00;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
